// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding, bit-counter width,
// frame length and the idle level of sclk, ss and MISO.
package spi_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StActive  = 2'b01,
      StWaitEnd = 2'b11
   } state_t;

   localparam int unsigned CntWidth  = 4;
   localparam int unsigned FrameLen  = 8;
   localparam logic        IdleLevel = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Input synchronizer with registered edge strobes.
// Ports:
//   i_clock   - system clock
//   i_reset_n - asynchronous active-low reset
//   i_din     - asynchronous input pin
//   o_sync    - synchronized level (SYNC_STAGES flops after the pin)
//   o_rise    - one-cycle strobe, SYNC_STAGES+1 clocks after a pin rising edge
//   o_fall    - one-cycle strobe, SYNC_STAGES+1 clocks after a pin falling edge
// SYNC_STAGES must be at least 2. All flops reset to the idle line level so that
// releasing reset with idle inputs produces no spurious strobes.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_din,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_level;

   assign w_level = r_sync[SYNC_STAGES-1];

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync <= {SYNC_STAGES{IdleLevel}};
         r_prev <= IdleLevel;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
         r_prev <= w_level;
         r_rise <= w_level & ~r_prev;
         r_fall <= ~w_level & r_prev;
      end
   end

   assign o_sync = w_level;
   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/spi_slave.sv
// 8-bit SPI slave, oversampling sclk/ss/MOSI on the local system clock.
// Frame: sclk idles high, master drives MOSI and samples MISO on sclk rising
// edges; the slave shifts MISO on sclk falling edges. LSB first by default.
// Build option: define SPI_SLAVE_MSB_FIRST_EN to run both shift registers MSB first.
// Ports:
//   clock, reset_n      - system clock, asynchronous active-low reset
//   sclk, ss, MOSI      - SPI inputs from the master (asynchronous)
//   MISO                - serial data to the master (1 when not in a frame)
//   tx_data, tx_load    - byte for the next frame, captured on tx_load while idle
//   tx_busy             - frame in progress; tx_load ignored while high
//   rx_data, rx_valid   - last complete received byte and its one-cycle strobe
//   frame_err           - one-cycle strobe when ss rises before 8 bits arrived
module spi_slave
   import spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       sclk,
   input  logic       ss,
   input  logic       MOSI,
   output logic       MISO,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   output logic       tx_busy,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err
);

   localparam logic [CntWidth-1:0] LastBit = CntWidth'(FrameLen - 1);
   localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

   logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
   logic w_ss_sync, w_ss_rise, w_ss_fall;
   logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
   logic w_unused_sync;

   state_t                r_state;
   logic [CntWidth-1:0]   r_bit_cnt;
   logic [FrameLen-1:0]   r_tx_buf;
   logic [FrameLen-1:0]   r_tx_shift;
   logic [FrameLen-1:0]   r_rx_shift;
   logic [FrameLen-1:0]   r_rx_data;
   logic                  r_rx_valid;
   logic                  r_frame_err;
   logic                  r_miso;
   logic                  r_tx_busy;

   logic                  w_tx_first;
   logic                  w_tx_next_bit;
   logic [FrameLen-1:0]   w_tx_next_shift;
   logic [FrameLen-1:0]   w_rx_next;
   logic                  w_last_capture;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_din     (sclk),
      .o_sync    (w_sclk_sync),
      .o_rise    (w_sclk_rise),
      .o_fall    (w_sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_din     (ss),
      .o_sync    (w_ss_sync),
      .o_rise    (w_ss_rise),
      .o_fall    (w_ss_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_din     (MOSI),
      .o_sync    (w_mosi_sync),
      .o_rise    (w_mosi_rise),
      .o_fall    (w_mosi_fall)
   );

   // Only the strobes of sclk/ss and the level of MOSI are needed.
   assign w_unused_sync = w_sclk_sync ^ w_ss_sync ^ w_mosi_rise ^ w_mosi_fall;

`ifdef SPI_SLAVE_MSB_FIRST_EN
   assign w_tx_first      = r_tx_buf[FrameLen-1];
   assign w_tx_next_bit   = r_tx_shift[FrameLen-2];
   assign w_tx_next_shift = {r_tx_shift[FrameLen-2:0], IdleLevel};
   assign w_rx_next       = {r_rx_shift[FrameLen-2:0], w_mosi_sync};
`else
   assign w_tx_first      = r_tx_buf[0];
   assign w_tx_next_bit   = r_tx_shift[1];
   assign w_tx_next_shift = {IdleLevel, r_tx_shift[FrameLen-1:1]};
   assign w_rx_next       = {w_mosi_sync, r_rx_shift[FrameLen-1:1]};
`endif

   assign w_last_capture = w_sclk_rise && (r_bit_cnt == LastBit);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_bit_cnt   <= '0;
         r_tx_buf    <= 8'hFF;
         r_tx_shift  <= '1;
         r_rx_shift  <= '0;
         r_rx_data   <= 8'h00;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_miso      <= IdleLevel;
         r_tx_busy   <= 1'b0;
      end else begin
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         unique case (r_state)
            StIdle: begin
               r_miso    <= IdleLevel;
               r_tx_busy <= 1'b0;
               if (tx_load) begin
                  r_tx_buf <= tx_data;
               end
               if (w_ss_fall) begin
                  r_tx_shift <= r_tx_buf;
                  r_miso     <= w_tx_first;
                  r_bit_cnt  <= '0;
                  r_tx_busy  <= 1'b1;
                  r_state    <= StActive;
               end
            end
            StActive: begin
               r_tx_busy <= 1'b1;
               if (w_sclk_rise) begin
                  r_rx_shift <= w_rx_next;
                  r_bit_cnt  <= r_bit_cnt + CntOne;
               end
               // The leading fall before the first rise belongs to frame setup.
               if (w_sclk_fall && (r_bit_cnt != '0)) begin
                  r_tx_shift <= w_tx_next_shift;
                  r_miso     <= w_tx_next_bit;
               end
               // A last capture coinciding with ss_rise still completes the byte.
               if (w_last_capture) begin
                  r_rx_data  <= w_rx_next;
                  r_rx_valid <= 1'b1;
                  r_miso     <= IdleLevel;
                  if (w_ss_rise) begin
                     r_tx_busy <= 1'b0;
                     r_state   <= StIdle;
                  end else begin
                     r_state   <= StWaitEnd;
                  end
               end else if (w_ss_rise) begin
                  r_frame_err <= 1'b1;
                  r_miso      <= IdleLevel;
                  r_tx_busy   <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            StWaitEnd: begin
               r_miso    <= IdleLevel;
               r_tx_busy <= 1'b1;
               if (w_ss_rise) begin
                  r_tx_busy <= 1'b0;
                  r_state   <= StIdle;
               end
            end
            default: begin
               r_miso    <= IdleLevel;
               r_tx_busy <= 1'b0;
               r_state   <= StIdle;
            end
         endcase
      end
   end

   assign MISO      = r_miso;
   assign tx_busy   = r_tx_busy;
   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged SPI master drives frames; expected received
// bytes and frame errors go into queues that a separate monitor pops whenever
// the DUT strobes rx_valid or frame_err.
module tb_spi_slave;

   localparam int Half = 8;  // sclk half period in system clocks

   logic       clock;
   logic       reset_n;
   logic       sclk;
   logic       ss;
   logic       MOSI;
   logic       MISO;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       tx_busy;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         rx_seen  = 0;
   int         err_seen = 0;
   logic [7:0] exp_rx_q[$];
   bit         exp_err_q[$];

   spi_slave #(.SYNC_STAGES(2)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .sclk      (sclk),
      .ss        (ss),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .tx_data   (tx_data),
      .tx_load   (tx_load),
      .tx_busy   (tx_busy),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Serial order as seen by a master that sends bit i of its byte i-th.
   function automatic logic [7:0] ord(input logic [7:0] b);
      logic [7:0] r;
`ifdef SPI_SLAVE_MSB_FIRST_EN
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
      r = b;
`endif
      return r;
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", name, got, exp);
      end
   endtask

   // Monitor: compare every strobe against the scoreboard queues.
   always @(negedge clock) begin
      if (reset_n && rx_valid) begin
         rx_seen++;
         if (exp_rx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_valid_unexpected: got rx_data %02h expected no pulse", rx_data);
         end else begin
            check("rx_data", rx_data, exp_rx_q.pop_front());
         end
      end
      if (reset_n && frame_err) begin
         err_seen++;
         if (exp_err_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_err_unexpected: got 1 expected 0");
         end else begin
            check("frame_err", {7'd0, frame_err}, {7'd0, exp_err_q.pop_front()});
         end
      end
   end

   // Master: nbits bits of mosi_byte, bit i sent i-th; MISO sampled on each rise.
   task automatic spi_frame(input logic [7:0] mosi_byte, input int nbits, input bit load_mid,
                            input bit end_ss, output logic [7:0] miso_byte);
      miso_byte = 8'h00;
      @(negedge clock);
      ss   = 1'b0;
      MOSI = mosi_byte[0];
      repeat (10) @(negedge clock);
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b0;
         MOSI = mosi_byte[i];
         repeat (Half) @(negedge clock);
         sclk = 1'b1;
         miso_byte[i] = MISO;
         if (nbits == 8 && i == 4) check("busy_mid_frame", {7'd0, tx_busy}, 8'd1);
         if (load_mid && i == 3) begin
            tx_data = 8'h11;
            tx_load = 1'b1;
            @(negedge clock);
            tx_load = 1'b0;
            repeat (Half - 1) @(negedge clock);
         end else begin
            repeat (Half) @(negedge clock);
         end
      end
      if (end_ss) begin
         ss = 1'b1;
         repeat (10) @(negedge clock);
      end
   endtask

   task automatic check_idle(input string tag, input logic [7:0] exp_rx);
      check({tag, "_miso"},  {7'd0, MISO},      8'd1);
      check({tag, "_busy"},  {7'd0, tx_busy},   8'd0);
      check({tag, "_rx"},    rx_data,           exp_rx);
      check({tag, "_valid"}, {7'd0, rx_valid},  8'd0);
      check({tag, "_err"},   {7'd0, frame_err}, 8'd0);
   endtask

   initial begin
      logic [7:0] got;
      sclk    = 1'b1;
      ss      = 1'b1;
      MOSI    = 1'b1;
      tx_data = 8'h00;
      tx_load = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check_idle("reset", 8'h00);
      reset_n = 1'b1;
      repeat (5) @(negedge clock);
      check_idle("post_reset", 8'h00);

      // Normal frame
      tx_data = 8'hA5;
      tx_load = 1'b1;
      @(negedge clock);
      tx_load = 1'b0;
      exp_rx_q.push_back(ord(8'h3C));
      spi_frame(8'h3C, 8, 1'b0, 1'b1, got);
      check("normal_miso", got, ord(8'hA5));
      check_idle("after_normal", ord(8'h3C));

      // Back-to-back frames without reload
      exp_rx_q.push_back(ord(8'h5A));
      spi_frame(8'h5A, 8, 1'b0, 1'b1, got);
      check("b2b1_miso", got, ord(8'hA5));
      exp_rx_q.push_back(ord(8'h0F));
      spi_frame(8'h0F, 8, 1'b0, 1'b1, got);
      check("b2b2_miso", got, ord(8'hA5));
      check("b2b2_rx", rx_data, ord(8'h0F));

      // tx_load while busy is ignored now and for the next frame
      exp_rx_q.push_back(ord(8'h96));
      spi_frame(8'h96, 8, 1'b1, 1'b1, got);
      check("busy_load_miso", got, ord(8'hA5));
      exp_rx_q.push_back(ord(8'h69));
      spi_frame(8'h69, 8, 1'b0, 1'b1, got);
      check("after_busy_miso", got, ord(8'hA5));

      // Aborted frame after 5 rising edges
      exp_err_q.push_back(1'b1);
      spi_frame(8'hE7, 5, 1'b0, 1'b1, got);
      check_idle("after_abort", ord(8'h69));

      // Reset mid-frame after 3 bits
      spi_frame(8'hC3, 3, 1'b0, 1'b0, got);
      reset_n = 1'b0;
      ss      = 1'b1;
      sclk    = 1'b1;
      MOSI    = 1'b1;
      repeat (2) @(negedge clock);
      check_idle("mid_reset", 8'h00);
      reset_n = 1'b1;
      repeat (6) @(negedge clock);
      exp_rx_q.push_back(ord(8'hC3));
      spi_frame(8'hC3, 8, 1'b0, 1'b1, got);
      check("post_reset_miso", got, 8'hFF);

      // Bit order: serial sequence 1,0,0,0,0,0,0,0
      exp_rx_q.push_back(ord(8'h01));
      spi_frame(8'h01, 8, 1'b0, 1'b1, got);
`ifdef SPI_SLAVE_MSB_FIRST_EN
      check("bit_order_rx", rx_data, 8'h80);
`else
      check("bit_order_rx", rx_data, 8'h01);
`endif

      repeat (20) @(negedge clock);
      check("rx_queue_left", 8'(exp_rx_q.size()), 8'd0);
      check("err_queue_left", 8'(exp_err_q.size()), 8'd0);
      check("rx_valid_count", 8'(rx_seen), 8'd7);
      check("frame_err_count", 8'(err_seen), 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
# spi_slave

8-bit SPI slave that receives the serial stream from `SPI_master` on `MOSI`, returns a byte on `MISO`, and hands received bytes to local logic. It sits directly downstream of the master, on the far side of the `sclk`/`ss`/`MOSI`/`MISO` link. The slave runs on its own system clock and oversamples all SPI inputs. Frame format matches the master: `sclk` idles high, LSB first, master drives `MOSI` and samples `MISO` on `sclk` rising edges.

## Interface
- `SYNC_STAGES`, default 2: flops in each input synchronizer for `sclk`, `ss` and `MOSI`; minimum 2.
- `clock`  input  1  system clock; all logic is on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `sclk`  input  1  SPI clock from the master; asynchronous to `clock`.
- `ss`  input  1  active-low slave select; asynchronous.
- `MOSI`  input  1  serial data from the master; asynchronous.
- `MISO`  output  1  serial data to the master.
- `tx_data`  input  8  byte to return in the next frame.
- `tx_load`  input  1  one-cycle strobe that captures `tx_data`.
- `tx_busy`  output  1  high while a frame is in progress; `tx_load` is ignored while it is high.
- `rx_data`  output  8  last complete received byte; holds its value until the next complete frame.
- `rx_valid`  output  1  one-cycle pulse when `rx_data` updates.
- `frame_err`  output  1  one-cycle pulse when a frame aborts.

## Operation
- **Input conditioning:** `sclk`, `ss` and `MOSI` pass through `SYNC_STAGES` synchronizers. Edge detectors on synchronized `sclk`/`ss` produce one-cycle `rise`, `fall`, `ss_fall` and `ss_rise` strobes.
- **State machine:** IDLE, ACTIVE, WAIT_END.
- **IDLE:**
  - `MISO` = 1.
  - `tx_busy` = 0.
  - `tx_load` copies `tx_data` into `tx_buf`.
  - On `ss_fall`: copy `tx_buf` into the shift register, clear the bit counter, go to ACTIVE.
- **ACTIVE:**
  - `tx_busy` = 1. `MISO` = shift-register bit 0 from the `ss_fall` cycle onward.
  - On `rise`, the cycle after it captures synchronized `MOSI` into the receive shift register (shifting right, new bit into bit 7) and increments the bit counter (4 bits, 0..8).
  - On each `fall` after at least one `rise`, shift the transmit register right with 1 filled in. `MISO` then presents the next bit.
  - When the counter reaches 8: load `rx_data` with the receive register, pulse `rx_valid`, go to WAIT_END.
  - On `ss_rise` with counter < 8: pulse `frame_err`, leave `rx_data` unchanged, go to IDLE.
- **WAIT_END:**
  - `MISO` = 1.
  - Further `sclk` edges are ignored.
  - On `ss_rise`: go to IDLE.
- **Simultaneous events:** if `ss_rise` arrives in the same cycle as the 8th capture, the capture completes (`rx_valid`, no `frame_err`) and the FSM goes straight to IDLE.
- **`tx_buf` persistence:** `tx_buf` is not cleared after a frame. Without a new `tx_load`, the same byte is sent again.

## Timing
- **Reset values:**
  - `MISO` = 1, `tx_busy` = 0.
  - `rx_data` = 8'h00, `rx_valid` = 0, `frame_err` = 0.
  - `tx_buf` = 8'hFF, state IDLE, counter 0.
  - Synchronizers reset to 1 (the idle levels of `sclk` and `ss`).
- **Reset mid-frame:** aborts the frame silently, with no `frame_err`.
- **Input latency:** `SYNC_STAGES`+1 clocks from a pin edge to its strobe.
- **`rx_valid` latency:** asserts `SYNC_STAGES`+2 clocks after the 8th `sclk` rising edge at the pin.
- **`MISO` update:** changes `SYNC_STAGES`+2 clocks after an `sclk` falling edge at the pin.
- **`sclk` phase requirement:** each `sclk` high or low phase must last at least `SYNC_STAGES`+3 `clock` periods. For example, the master's div_8 setting with equal clocks and `SYNC_STAGES`=2 meets this; div_2 does not, and that case is unsupported.
- **`ss` setup:** `ss` must be low for at least `SYNC_STAGES`+3 clocks before the first `sclk` edge, so that `MISO` bit 0 is valid before the master's first rising edge.

## Configuration
- **`SPI_SLAVE_MSB_FIRST_EN` defined:** both shift registers run MSB first. Receive shifts left with the new bit into bit 0; `MISO` presents bit 7 first. Use this only with a master built for MSB-first order.
- **Undefined (default):** LSB first as described above, compatible with `SPI_master`.

## Structure
- Shared package `spi_pkg`: state encoding (IDLE=2'b00, ACTIVE=2'b01, WAIT_END=2'b11), bit-counter width 4, frame length constant 8, idle line level 1'b1.
- One sub-module, `spi_sync_edge`: a parameterized `SYNC_STAGES` synchronizer with rise/fall strobe outputs. It is instantiated three times: `sclk`, `ss`, and `MOSI` with its strobes unused.

## Test plan
- **Normal frame:** reset, then `tx_load` with `tx_data`=8'hA5; master sends 8'h3C at div_8. Expect `rx_data`=8'h3C with a single `rx_valid` pulse, master `dataRecieved`=8'hA5, and `frame_err` never high.
- **Back-to-back frames without reload:** send two frames. Both return 8'hA5, and `rx_data` updates to each new byte.
- **`tx_load` while busy:** pulse `tx_load`=8'h11 during ACTIVE. It is ignored, the current frame sends the old byte, and the next frame also sends the old byte.
- **Aborted frame:** raise `ss` after 5 `sclk` rising edges. Expect a `frame_err` pulse, no `rx_valid`, `rx_data` holding its previous value, and `MISO`=1 in IDLE.
- **Reset mid-frame:** assert `reset_n`=0 after 3 bits. All outputs return to reset values, no pulses occur, and a following full frame of 8'hC3 is received correctly.
- **Bit order under `SPI_SLAVE_MSB_FIRST_EN`:** with the macro defined, send serial bit sequence 1,0,0,0,0,0,0,0. Expect `rx_data`=8'h80 (8'h01 with the macro undefined).
